// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } owner_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the CPU data port, the scanner and the RAM macro.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_gnt;
   logic [DATA_W-1:0] vid_rdata;
   logic              vid_rvalid;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
      input  vid_req, vid_addr,
      output vid_gnt, vid_rdata, vid_rvalid,
      output ram_addr, ram_we, ram_wdata,
      input  ram_rdata
   );

   // Requesters and RAM side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
      output vid_req, vid_addr,
      input  vid_gnt, vid_rdata, vid_rvalid,
      input  ram_addr, ram_we, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the scanner was denied.
module arb_wait_counter
   import ram_arb_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic             sat,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_C)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == MAX_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU (priority) and the display
// scanner, with a bounded wait that forces a scanner grant.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int VID_MAX_WAIT = 4
) (
   input logic               clk,
   input logic               rst,
   ram_port_arbiter_if.slave bus
);

   // rd_owner | meaning
   // OWN_NONE | no read in flight, ram_rdata is ignored
   // OWN_CPU  | ram_rdata this cycle belongs to the CPU
   // OWN_VID  | ram_rdata this cycle belongs to the scanner
   owner_e            rd_owner;
   logic              cpu_gnt_c;
   logic              vid_gnt_c;
   logic              sat;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] vid_rdata_q;
   logic              cpu_rvalid_c;
   logic              vid_rvalid_c;

   always_comb begin
      cpu_gnt_c = 1'b0;
      vid_gnt_c = 1'b0;
      if (!rst) begin
         if (bus.vid_req && sat) begin
            vid_gnt_c = 1'b1;
         end else if (bus.cpu_req) begin
            cpu_gnt_c = 1'b1;
         end else if (bus.vid_req) begin
            vid_gnt_c = 1'b1;
         end
      end
   end

   always_comb begin
      bus.ram_addr  = '0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      if (vid_gnt_c) begin
         bus.ram_addr = bus.vid_addr;
      end else if (cpu_gnt_c) begin
         bus.ram_addr  = bus.cpu_addr;
         bus.ram_we    = bus.cpu_we;
         bus.ram_wdata = bus.cpu_wdata;
      end
   end

   assign bus.cpu_gnt   = cpu_gnt_c;
   assign bus.vid_gnt   = vid_gnt_c;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt_c;

   arb_wait_counter #(
      .MAX (VID_MAX_WAIT)
   ) u_wait (
      .clk (clk),
      .rst (rst),
      .inc (bus.vid_req & ~vid_gnt_c),
      .clr (vid_gnt_c | ~bus.vid_req),
      .sat (sat),
      .cnt (wait_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner <= OWN_NONE;
      end else if (vid_gnt_c) begin
         rd_owner <= OWN_VID;
      end else if (cpu_gnt_c && !bus.cpu_we) begin
         rd_owner <= OWN_CPU;
      end else begin
         rd_owner <= OWN_NONE;
      end
   end

   // A read in flight when reset arrives is dropped, not delivered.
   assign cpu_rvalid_c = (rd_owner == OWN_CPU) && !rst;
   assign vid_rvalid_c = (rd_owner == OWN_VID) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         if (cpu_rvalid_c) cpu_rdata_q <= bus.ram_rdata;
         if (vid_rvalid_c) vid_rdata_q <= bus.ram_rdata;
      end
   end

   assign bus.cpu_rvalid = cpu_rvalid_c;
   assign bus.vid_rvalid = vid_rvalid_c;
   assign bus.cpu_rdata  = cpu_rvalid_c ? bus.ram_rdata : cpu_rdata_q;
   assign bus.vid_rdata  = vid_rvalid_c ? bus.ram_rdata : vid_rdata_q;

endmodule
